// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, ALU op codes and operand-select encodings.
package cpu_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;

  localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [3:0] ALU_OP_SUB  = 4'b0001;
  // The ALU drives 0 for this op, so a bubble never produces a stray result.
  localparam logic [3:0] ALU_OP_ZERO = 4'b1111;

  typedef enum logic {
    SRC1_RS1 = 1'b0,
    SRC1_PC  = 1'b1
  } src1_sel_e;

  typedef enum logic {
    SRC2_RS2 = 1'b0,
    SRC2_IMM = 1'b1
  } src2_sel_e;

endpackage

// File: rtl/id_ex_operand_stage_fwd_select.sv
// Combinational priority forward mux for one source register.
// EX/MEM beats MEM/WB beats register file; index 0 always reads as 0.
// With ID_EX_FORWARDING_EN undefined the forward sources are ignored.
module fwd_select #(
  parameter int XLEN      = 32,
  parameter int REG_IDX_W = 5
) (
  input  logic [REG_IDX_W-1:0] idx,
  input  logic [XLEN-1:0]      rf_data,
  input  logic                 exmem_reg_write,
  input  logic [REG_IDX_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]      exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [REG_IDX_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]      memwb_result,
  output logic [XLEN-1:0]      value
);

  // Resolve the newest producer of idx, falling back to the register file.
  always_comb begin
    value = rf_data;
`ifdef ID_EX_FORWARDING_EN
    if (exmem_reg_write && (exmem_rd == idx)) begin
      value = exmem_result;
    end else if (memwb_reg_write && (memwb_rd == idx)) begin
      value = memwb_result;
    end
`endif
    if (idx == '0) begin
      value = '0;
    end
  end

`ifndef ID_EX_FORWARDING_EN
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
`endif

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register with operand selection and RAW forwarding.
// Optional feature macro: ID_EX_FORWARDING_EN (forwarding + stall refresh).
// While stalled, the two fwd_select instances are pointed at the held
// indices and held operand values, so a late-arriving producer refreshes
// the stale operand without a second mux pair.
module id_ex_operand_stage #(
  parameter int XLEN      = cpu_pkg::XLEN,
  parameter int REG_IDX_W = cpu_pkg::REG_IDX_W
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [REG_IDX_W-1:0] rs1_idx,
  input  logic [REG_IDX_W-1:0] rs2_idx,
  input  logic [REG_IDX_W-1:0] rd_idx,
  input  logic [XLEN-1:0]      rs1_data,
  input  logic [XLEN-1:0]      rs2_data,
  input  logic [XLEN-1:0]      imm,
  input  logic [XLEN-1:0]      pc,
  input  logic                 src1_sel,
  input  logic                 src2_sel,
  input  logic [3:0]           alu_op_in,
  input  logic                 reg_write_in,
  input  logic                 is_branch_in,
  input  logic                 exmem_reg_write,
  input  logic [REG_IDX_W-1:0] exmem_rd,
  input  logic [XLEN-1:0]      exmem_result,
  input  logic                 memwb_reg_write,
  input  logic [REG_IDX_W-1:0] memwb_rd,
  input  logic [XLEN-1:0]      memwb_result,
  output logic                 out_valid,
  output logic [XLEN-1:0]      alu_in_1,
  output logic [XLEN-1:0]      alu_in_2,
  output logic [3:0]           alu_op,
  output logic [XLEN-1:0]      store_data,
  output logic [REG_IDX_W-1:0] rd_idx_out,
  output logic                 reg_write_out,
  output logic                 is_branch_out,
  output logic [XLEN-1:0]      pc_out
);

  import cpu_pkg::*;

  logic                 valid_q,      valid_d;
  logic [XLEN-1:0]      alu_in_1_q,   alu_in_1_d;
  logic [XLEN-1:0]      alu_in_2_q,   alu_in_2_d;
  logic [3:0]           alu_op_q,     alu_op_d;
  logic [XLEN-1:0]      store_data_q, store_data_d;
  logic [REG_IDX_W-1:0] rd_idx_q,     rd_idx_d;
  logic                 reg_write_q,  reg_write_d;
  logic                 is_branch_q,  is_branch_d;
  logic [XLEN-1:0]      pc_q,         pc_d;
  logic [REG_IDX_W-1:0] rs1_idx_q,    rs1_idx_d;
  logic [REG_IDX_W-1:0] rs2_idx_q,    rs2_idx_d;
  logic                 src1_sel_q,   src1_sel_d;
  logic                 src2_sel_q,   src2_sel_d;

  logic [REG_IDX_W-1:0] fwd_rs1_idx, fwd_rs2_idx;
  logic [XLEN-1:0]      fwd_rs1_base, fwd_rs2_base;
  logic [XLEN-1:0]      fwd_rs1, fwd_rs2;

  // Capture looks at ID; a stall looks at what is already held.
  always_comb begin
    fwd_rs1_idx  = stall ? rs1_idx_q    : rs1_idx;
    fwd_rs2_idx  = stall ? rs2_idx_q    : rs2_idx;
    fwd_rs1_base = stall ? alu_in_1_q   : rs1_data;
    fwd_rs2_base = stall ? store_data_q : rs2_data;
  end

  fwd_select #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_rs1 (
    .idx             (fwd_rs1_idx),
    .rf_data         (fwd_rs1_base),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (fwd_rs1)
  );

  fwd_select #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) u_fwd_rs2 (
    .idx             (fwd_rs2_idx),
    .rf_data         (fwd_rs2_base),
    .exmem_reg_write (exmem_reg_write),
    .exmem_rd        (exmem_rd),
    .exmem_result    (exmem_result),
    .memwb_reg_write (memwb_reg_write),
    .memwb_rd        (memwb_rd),
    .memwb_result    (memwb_result),
    .value           (fwd_rs2)
  );

  // Next-state: flush/empty-capture load a bubble, stall holds (with refresh), else capture.
  always_comb begin
    valid_d      = valid_q;
    alu_in_1_d   = alu_in_1_q;
    alu_in_2_d   = alu_in_2_q;
    alu_op_d     = alu_op_q;
    store_data_d = store_data_q;
    rd_idx_d     = rd_idx_q;
    reg_write_d  = reg_write_q;
    is_branch_d  = is_branch_q;
    pc_d         = pc_q;
    rs1_idx_d    = rs1_idx_q;
    rs2_idx_d    = rs2_idx_q;
    src1_sel_d   = src1_sel_q;
    src2_sel_d   = src2_sel_q;

    if (flush || (!stall && !in_valid)) begin
      valid_d      = 1'b0;
      alu_in_1_d   = '0;
      alu_in_2_d   = '0;
      alu_op_d     = ALU_OP_ZERO;
      store_data_d = '0;
      rd_idx_d     = '0;
      reg_write_d  = 1'b0;
      is_branch_d  = 1'b0;
      pc_d         = '0;
      rs1_idx_d    = '0;
      rs2_idx_d    = '0;
      src1_sel_d   = SRC1_RS1;
      src2_sel_d   = SRC2_RS2;
    end else if (stall) begin
`ifdef ID_EX_FORWARDING_EN
      if (valid_q) begin
        if (src1_sel_q == SRC1_RS1) alu_in_1_d = fwd_rs1;
        if (src2_sel_q == SRC2_RS2) alu_in_2_d = fwd_rs2;
        store_data_d = fwd_rs2;
      end
`endif
    end else begin
      valid_d      = 1'b1;
      alu_in_1_d   = (src1_sel == SRC1_PC)  ? pc  : fwd_rs1;
      alu_in_2_d   = (src2_sel == SRC2_IMM) ? imm : fwd_rs2;
      alu_op_d     = alu_op_in;
      store_data_d = fwd_rs2;
      rd_idx_d     = rd_idx;
      reg_write_d  = reg_write_in;
      is_branch_d  = is_branch_in;
      pc_d         = pc;
      rs1_idx_d    = rs1_idx;
      rs2_idx_d    = rs2_idx;
      src1_sel_d   = src1_sel;
      src2_sel_d   = src2_sel;
    end
  end

  // Stage register with synchronous reset to a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q      <= 1'b0;
      alu_in_1_q   <= '0;
      alu_in_2_q   <= '0;
      alu_op_q     <= ALU_OP_ZERO;
      store_data_q <= '0;
      rd_idx_q     <= '0;
      reg_write_q  <= 1'b0;
      is_branch_q  <= 1'b0;
      pc_q         <= '0;
      rs1_idx_q    <= '0;
      rs2_idx_q    <= '0;
      src1_sel_q   <= SRC1_RS1;
      src2_sel_q   <= SRC2_RS2;
    end else begin
      valid_q      <= valid_d;
      alu_in_1_q   <= alu_in_1_d;
      alu_in_2_q   <= alu_in_2_d;
      alu_op_q     <= alu_op_d;
      store_data_q <= store_data_d;
      rd_idx_q     <= rd_idx_d;
      reg_write_q  <= reg_write_d;
      is_branch_q  <= is_branch_d;
      pc_q         <= pc_d;
      rs1_idx_q    <= rs1_idx_d;
      rs2_idx_q    <= rs2_idx_d;
      src1_sel_q   <= src1_sel_d;
      src2_sel_q   <= src2_sel_d;
    end
  end

`ifndef ID_EX_FORWARDING_EN
  logic unused_sel;
  assign unused_sel = ^{src1_sel_q, src2_sel_q};
`endif

  assign out_valid     = valid_q;
  assign alu_in_1      = alu_in_1_q;
  assign alu_in_2      = alu_in_2_q;
  assign alu_op        = alu_op_q;
  assign store_data    = store_data_q;
  assign rd_idx_out    = rd_idx_q;
  assign reg_write_out = reg_write_q;
  assign is_branch_out = is_branch_q;
  assign pc_out        = pc_q;

endmodule
